// File: rtl/kamus_mc_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// kamus_mc_ctrl
//
// Multi-cycle control unit for the kamus-v RV32I core. Walks one instruction
// at a time through FETCH -> WAIT_INS -> DECODE -> EXECUTE -> (MEM_REQ ->
// MEM_WAIT) -> WB and drives the memory handshakes, IR load, PC update,
// register-file write and write-back mux select.
//
// Optional feature macro: KAMUS_CTRL_ILLEGAL_TRAP_EN
//   defined   : illegal opcodes and ECALL/EBREAK enter TRAP from DECODE.
//   undefined : they retire as NOPs and trap_o is constant 0.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   imem_req_o/gnt_i/rvalid_i  instruction fetch handshake
//   ir_we_o                load instruction register
//   opcode_i, func3_i      decoded instruction fields
//   branch_taken_i         ALU compare result, sampled in EXECUTE
//   alu_en_o               ALU operands/result valid
//   dmem_req_o/we_o/gnt_i/rvalid_i  data memory handshake
//   rf_we_o, wb_sel_o      register write enable and write-back source
//   pc_we_o, pc_sel_o      PC update and next-PC source
//   instret_o, trap_o      retire / trap-entry pulses
// ---------------------------------------------------------------------------
module kamus_mc_ctrl (
   input  logic       clk_i,
   input  logic       rst_ni,
   output logic       imem_req_o,
   input  logic       imem_gnt_i,
   input  logic       imem_rvalid_i,
   output logic       ir_we_o,
   input  logic [6:0] opcode_i,
   input  logic [2:0] func3_i,
   input  logic       branch_taken_i,
   output logic       alu_en_o,
   output logic       dmem_req_o,
   output logic       dmem_we_o,
   input  logic       dmem_gnt_i,
   input  logic       dmem_rvalid_i,
   output logic       rf_we_o,
   output logic [1:0] wb_sel_o,
   output logic       pc_we_o,
   output logic [1:0] pc_sel_o,
   output logic       instret_o,
   output logic       trap_o
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_REL   = 2'b01;
   localparam logic [1:0] PC_JALR  = 2'b10;
   localparam logic [1:0] PC_TRAP  = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_INS,
      S_DECODE,
      S_EXECUTE,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_WB,
      S_TRAP
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [6:0] r_opcode;
   logic       r_taken;
   logic       w_trap_req;

`ifdef KAMUS_CTRL_ILLEGAL_TRAP_EN
   function automatic logic f_is_legal(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
         OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: f_is_legal = 1'b1;
         default:                                     f_is_legal = 1'b0;
      endcase
   endfunction

   // ECALL/EBREAK share func3 000; the CSR forms of SYSTEM do not trap.
   assign w_trap_req = !f_is_legal(opcode_i) ||
                       ((opcode_i == OP_SYSTEM) && (func3_i == 3'b000));
`else
   logic w_unused_func3;
   assign w_unused_func3 = ^func3_i;
   assign w_trap_req     = 1'b0;
`endif

   // Opcode is captured while the decoder settles so later states do not
   // depend on the decoder holding its output; the branch result is frozen
   // at EXECUTE so later ALU operand changes cannot redirect the PC.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
         r_taken  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opcode <= opcode_i;
         end
         if (r_state == S_EXECUTE) begin
            r_taken <= branch_taken_i;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      imem_req_o = 1'b0;
      ir_we_o    = 1'b0;
      alu_en_o   = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      rf_we_o    = 1'b0;
      wb_sel_o   = WB_ALU;
      pc_we_o    = 1'b0;
      pc_sel_o   = PC_PLUS4;
      instret_o  = 1'b0;
      trap_o     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_gnt_i) begin
               w_next = S_WAIT_INS;
            end
         end
         S_WAIT_INS: begin
            // An rvalid alongside the grant arrives while still in FETCH and
            // is therefore never seen here.
            if (imem_rvalid_i) begin
               ir_we_o = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: begin
            w_next = w_trap_req ? S_TRAP : S_EXECUTE;
         end
         S_EXECUTE: begin
            alu_en_o = 1'b1;
            if ((r_opcode == OP_LOAD) || (r_opcode == OP_STORE)) begin
               w_next = S_MEM_REQ;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM_REQ: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = (r_opcode == OP_STORE);
            if (dmem_gnt_i) begin
               w_next = S_MEM_WAIT;
            end
         end
         S_MEM_WAIT: begin
            if (dmem_rvalid_i) begin
               w_next = S_WB;
            end
         end
         S_WB: begin
            pc_we_o   = 1'b1;
            instret_o = 1'b1;
            w_next    = S_FETCH;
            case (r_opcode)
               OP_OP, OP_IMM, OP_AUIPC: begin
                  rf_we_o  = 1'b1;
                  wb_sel_o = WB_ALU;
               end
               OP_LUI: begin
                  rf_we_o  = 1'b1;
                  wb_sel_o = WB_IMM;
               end
               OP_LOAD: begin
                  rf_we_o  = 1'b1;
                  wb_sel_o = WB_MEM;
               end
               OP_JAL: begin
                  rf_we_o  = 1'b1;
                  wb_sel_o = WB_PC4;
                  pc_sel_o = PC_REL;
               end
               OP_JALR: begin
                  rf_we_o  = 1'b1;
                  wb_sel_o = WB_PC4;
                  pc_sel_o = PC_JALR;
               end
               OP_BRANCH: begin
                  pc_sel_o = r_taken ? PC_REL : PC_PLUS4;
               end
               // STORE, FENCE, SYSTEM and (without trapping) illegal
               // opcodes simply advance the PC.
               default: begin
               end
            endcase
         end
         S_TRAP: begin
            w_next = S_FETCH;
`ifdef KAMUS_CTRL_ILLEGAL_TRAP_EN
            pc_we_o  = 1'b1;
            pc_sel_o = PC_TRAP;
            trap_o   = 1'b1;
`endif
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
